// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Holds a shadow/active digit buffer pair, walks one digit per slot with a
// blanking interval at the start of every slot, and copies shadow into
// active atomically at frame boundaries when a commit is pending.
module sev_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          lz_blank,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                    wr_data,
    input  logic                          clr,
    input  logic                          commit,
    output logic [3:0]                    seg_num,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_done,
    output logic                          commit_ack
);

    localparam int AW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(CLK_DIV);

    localparam logic [CW-1:0] CNT_LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE_DRIVE = CW'(BLANK_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST      = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   NUM_DIGITS_W  = (AW + 1)'(NUM_DIGITS);
    localparam logic [3:0]    CODE_BLANK    = 4'hF;
    localparam logic [3:0]    CODE_ZERO     = 4'h0;
    localparam logic [3:0]    CODE_FIRST_BL = 4'd12;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   slot_idx;
    logic            pending;
    logic [3:0]      shadow [NUM_DIGITS];
    logic [3:0]      active [NUM_DIGITS];
    logic [3:0]      disp   [NUM_DIGITS];

    logic            slot_end;
    logic            frame_edge;
    logic            drive;
    logic            wr_in_range;
    logic [NUM_DIGITS-1:0] an_next;

    // Slot and frame boundary decode from the prescaler and slot index.
    // NOTE: every combinational output gets a default before any condition,
    // otherwise an unassigned path would infer a latch.
    always_comb begin
        slot_end    = 1'b0;
        frame_edge  = 1'b0;
        drive       = 1'b0;
        wr_in_range = 1'b0;
        slot_end    = (cnt == CNT_LAST);
        frame_edge  = en && slot_end && (slot_idx == IDX_LAST);
        drive       = en && (state == ST_DRIVE);
        wr_in_range = ({1'b0, wr_addr} < NUM_DIGITS_W);
    end

    // Prescaler, slot index and blank/drive FSM; held at slot 0 while disabled.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            slot_idx <= '0;
            state    <= ST_BLANK;
        end else if (!en) begin
            cnt      <= '0;
            slot_idx <= '0;
            state    <= ST_BLANK;
        end else begin
            if (slot_end) begin
                cnt      <= '0;
                slot_idx <= (slot_idx == IDX_LAST) ? '0 : slot_idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                ST_BLANK: if (cnt == CNT_PRE_DRIVE) state <= ST_DRIVE;
                ST_DRIVE: if (slot_end)             state <= ST_BLANK;
                default:                            state <= ST_BLANK;
            endcase
        end
    end

    // Shadow buffer writes; clear has priority over a same-cycle write.
    // NOTE: the digit buffers are small register files with a defined
    // all-blank power-up value, so they are reset like ordinary flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= CODE_BLANK;
        end else if (clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= CODE_BLANK;
        end else if (wr_en && wr_in_range) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Commit bookkeeping: copy pre-edge shadow into active at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) active[i] <= CODE_BLANK;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            frame_done <= frame_edge;
            commit_ack <= frame_edge && pending;
            if (frame_edge) begin
                if (pending) begin
                    for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
                end
                // A commit raised in the boundary cycle waits for the next frame.
                pending <= commit;
            end else begin
                pending <= pending | commit;
            end
        end
    end

    // Leading-zero suppression, scanned from the most significant digit down.
    always_comb begin
        logic above_blank;
        above_blank = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            disp[i] = active[i];
            if (lz_blank && (i > 0) && (active[i] == CODE_ZERO) && above_blank) begin
                disp[i] = CODE_BLANK;
            end
            above_blank = above_blank &&
                          ((active[i] == CODE_ZERO) || (active[i] >= CODE_FIRST_BL));
        end
    end

    // Anode select for the current slot; only ever one bit low.
    always_comb begin
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (drive && (slot_idx == AW'(i))) an_next[i] = 1'b0;
        end
    end

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n     <= '1;
            seg_num  <= CODE_BLANK;
            scan_idx <= '0;
        end else begin
            an_n     <= an_next;
            seg_num  <= drive ? disp[slot_idx] : CODE_BLANK;
            scan_idx <= en ? slot_idx : '0;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Self-checking bench for sev_seg_scan_ctrl with a frame-position reference
// model feeding a scoreboard queue that a negedge monitor drains.
module tb_sev_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       lz_blank;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       clr;
    logic       commit;
    logic [3:0] seg_num;
    logic [N-1:0] an_n;
    logic [1:0] scan_idx;
    logic       frame_done;
    logic       commit_ack;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] an;
        logic [3:0]   seg;
        logic [1:0]   idx;
        logic         fd;
        logic         ack;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state.
    logic [3:0] m_shadow [N];
    logic [3:0] m_active [N];
    logic       m_pending;
    int         m_t;

    sev_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .CLK_DIV     (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .lz_blank  (lz_blank),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr       (clr),
        .commit    (commit),
        .seg_num   (seg_num),
        .an_n      (an_n),
        .scan_idx  (scan_idx),
        .frame_done(frame_done),
        .commit_ack(commit_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Displayed code for digit i: a zero is hidden only when leading-zero
    // blanking is on, it is not digit 0, and nothing visible sits above it.
    function automatic logic [3:0] m_disp(input int i);
        if (!lz_blank || i == 0 || m_active[i] != 4'h0) return m_active[i];
        for (int j = i + 1; j < N; j++) begin
            if (m_active[j] >= 4'd1 && m_active[j] <= 4'd11) return m_active[i];
        end
        return 4'hF;
    endfunction

    // Reference model: position within the frame decides slot and phase.
    initial begin
        exp_t e;
        int   slot;
        int   phase;
        logic bnd;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    m_shadow[i] = 4'hF;
                    m_active[i] = 4'hF;
                end
                m_pending = 1'b0;
                m_t       = 0;
            end else begin
                e.an  = '1;
                e.seg = 4'hF;
                e.idx = 2'd0;
                e.fd  = 1'b0;
                e.ack = 1'b0;
                bnd   = 1'b0;
                if (en) begin
                    slot  = m_t / DIV;
                    phase = m_t % DIV;
                    e.idx = slot[1:0];
                    if (phase >= BLK) begin
                        e.an[slot] = 1'b0;
                        e.seg      = m_disp(slot);
                    end
                    bnd   = (m_t == FRAME - 1);
                    e.fd  = bnd;
                    e.ack = bnd && m_pending;
                end
                if (bnd) begin
                    if (m_pending) m_active = m_shadow;
                    m_pending = commit;
                end else begin
                    m_pending = m_pending | commit;
                end
                if (clr) begin
                    for (int i = 0; i < N; i++) m_shadow[i] = 4'hF;
                end else if (wr_en && int'(wr_addr) < N) begin
                    m_shadow[wr_addr] = wr_data;
                end
                m_t = en ? (m_t + 1) % FRAME : 0;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard each cycle.
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                check("reset_an_n", 32'(an_n), 32'hF);
                check("reset_seg_num", 32'(seg_num), 32'hF);
                check("reset_frame_done", 32'(frame_done), 32'h0);
                check("reset_commit_ack", 32'(commit_ack), 32'h0);
            end else if (sb_q.size() > 0) begin
                me = sb_q.pop_front();
                check("an_n", 32'(an_n), 32'(me.an));
                check("seg_num", 32'(seg_num), 32'(me.seg));
                check("scan_idx", 32'(scan_idx), 32'(me.idx));
                check("frame_done", 32'(frame_done), 32'(me.fd));
                check("commit_ack", 32'(commit_ack), 32'(me.ack));
                check("an_n_one_low", 32'($countones(~an_n) <= 1), 32'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        step(1);
        commit = 1'b0;
    endtask

    // Advance until the model reports the given frame position for this cycle.
    task automatic wait_t(input int target);
        int n;
        n = 0;
        while (m_t != target && n < 4 * FRAME) begin
            step(1);
            n++;
        end
        check("wait_frame_pos", 32'(m_t), 32'(target));
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        lz_blank = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 4'd0;
        clr      = 1'b0;
        commit   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);

        // Blank scan with no writes.
        en = 1'b1;
        step(2 * FRAME);

        // Write 4,3,2,1 into slots 0..3 and commit.
        write(2'd3, 4'd1);
        write(2'd2, 4'd2);
        write(2'd1, 4'd3);
        write(2'd0, 4'd4);
        pulse_commit();
        step(2 * FRAME);

        // Leading-zero suppression on and off.
        write(2'd3, 4'd0);
        write(2'd2, 4'd0);
        write(2'd1, 4'd7);
        write(2'd0, 4'd0);
        pulse_commit();
        lz_blank = 1'b1;
        step(2 * FRAME);
        lz_blank = 1'b0;
        step(FRAME);

        // Write in the boundary cycle while a commit is pending.
        write(2'd0, 4'd5);
        pulse_commit();
        wait_t(FRAME - 1);
        write(2'd0, 4'd9);
        step(FRAME + 2);
        pulse_commit();
        step(2 * FRAME);

        // Commit raised in the boundary cycle itself.
        write(2'd2, 4'd6);
        wait_t(FRAME - 1);
        pulse_commit();
        step(2 * FRAME);

        // Clear and write in the same cycle, then commit.
        clr     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = 4'd5;
        step(1);
        clr   = 1'b0;
        wr_en = 1'b0;
        pulse_commit();
        step(2 * FRAME);

        // Disable mid-drive of slot 2 with a pending commit.
        write(2'd0, 4'd8);
        write(2'd3, 4'd11);
        pulse_commit();
        wait_t(2 * DIV + 4);
        en = 1'b0;
        step(6);
        en = 1'b1;
        step(2 * FRAME);

        // Asynchronous reset during drive with a pending commit.
        write(2'd1, 4'd10);
        pulse_commit();
        wait_t(DIV + 4);
        #1 rst_n = 1'b0;
        #1;
        check("async_an_n", 32'(an_n), 32'hF);
        check("async_seg_num", 32'(seg_num), 32'hF);
        step(2);
        rst_n = 1'b1;
        step(2 * FRAME);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 4'($urandom_range(0, 15));
            clr     = ($urandom_range(0, 40) == 0);
            commit  = ($urandom_range(0, 25) == 0);
            en      = ($urandom_range(0, 60) != 0);
            if ($urandom_range(0, 50) == 0) lz_blank = ~lz_blank;
            step(1);
        end
        wr_en  = 1'b0;
        clr    = 1'b0;
        commit = 1'b0;
        en     = 1'b1;
        step(2 * FRAME);
        en = 1'b0;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
